// File: rtl/core_launch_ctrl.sv
// core_launch_ctrl: sends the PC-write launch packet to the core, then tracks the
// run until the core returns to IDLE, faults, or overruns its cycle budget.
package core_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_e;
endpackage

module core_launch_ctrl
  import core_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              n_reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_pc_i,
  input  logic [CNT_W-1:0]  timeout_i,
  input  logic              clear_i,
  input  state_e            core_state_i,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i,
  output logic [ADDR_W-1:0] pkt_pc_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic              reject_o,
  output logic [CNT_W-1:0]  run_cycles_o
);
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_RUN, S_RUN, S_ERR} ctrl_e;

  ctrl_e            state, state_n;
  logic [CNT_W-1:0] cnt_q, tmo_q;
  logic             capture, cnt_en, done_n, tmo_n, rej_n, tmo_hit;

  assign tmo_hit      = (tmo_q != '0) && (cnt_q == tmo_q);
  assign run_cycles_o = cnt_q;

  // Core ERR outranks the timeout, which outranks normal progress. The exit
  // cycle into S_ERR does not count, so a timeout reports exactly the budget.
  always_comb begin
    state_n = state;
    capture = 1'b0;
    cnt_en  = 1'b0;
    done_n  = 1'b0;
    tmo_n   = 1'b0;
    rej_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (core_state_i == IDLE) begin
            capture = 1'b1;
            state_n = S_SEND;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      S_SEND: if (pkt_valid_o && pkt_ready_i) state_n = S_WAIT_RUN;
      S_WAIT_RUN, S_RUN: begin
        if (core_state_i == ERR) begin
          state_n = S_ERR;
        end else if (tmo_hit) begin
          tmo_n   = 1'b1;
          state_n = S_ERR;
        end else begin
          cnt_en = 1'b1;
          if (state == S_WAIT_RUN && core_state_i == RUN) begin
            state_n = S_RUN;
          end else if (state == S_RUN && core_state_i == IDLE) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_ERR: if (clear_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state       <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      pkt_pc_o    <= '0;
      pkt_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      timeout_o   <= 1'b0;
      reject_o    <= 1'b0;
    end else begin
      state <= state_n;
      if (capture) begin
        pkt_pc_o <= start_pc_i;
        tmo_q    <= timeout_i;
        cnt_q    <= '0;
      end else if (cnt_en && !(&cnt_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Status flags come from the next state so they line up with it.
      pkt_valid_o <= (state_n == S_SEND);
      busy_o      <= (state_n == S_SEND) || (state_n == S_WAIT_RUN) || (state_n == S_RUN);
      err_o       <= (state_n == S_ERR);
      done_o      <= done_n;
      timeout_o   <= tmo_n;
      reject_o    <= rej_n;
    end
  end
endmodule

// File: tb/tb_core_launch_ctrl.sv
// Bench for core_launch_ctrl: a 16-bit-counter and a 4-bit-counter instance share
// stimulus; launch outcomes are predicted from event timing by a scenario model.
module tb_core_launch_ctrl;
  import core_pkg::*;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, clear = 1'b0, ready = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [15:0]   tmo_in = '0;
  state_e        core = IDLE;

  logic          vld_b, vld_s, busy_b, busy_s, done_b, done_s, err_b, err_s;
  logic          tmo_b, tmo_s, rej_b, rej_s;
  logic [AW-1:0] pc_b, pc_s;
  logic [15:0]   cyc_b;
  logic [3:0]    cyc_s;
  logic [1:0]    vld, busy, done, err, tmo, rej;

  assign vld  = {vld_s, vld_b};
  assign busy = {busy_s, busy_b};
  assign done = {done_s, done_b};
  assign err  = {err_s, err_b};
  assign tmo  = {tmo_s, tmo_b};
  assign rej  = {rej_s, rej_b};

  int n_cmp = 0;
  int n_bad = 0;

  core_launch_ctrl #(.ADDR_W(AW), .CNT_W(16)) u_big (
    .clk(clk), .n_reset_i(n_reset), .start_i(start), .start_pc_i(start_pc),
    .timeout_i(tmo_in), .clear_i(clear), .core_state_i(core),
    .pkt_valid_o(vld_b), .pkt_ready_i(ready), .pkt_pc_o(pc_b), .busy_o(busy_b),
    .done_o(done_b), .err_o(err_b), .timeout_o(tmo_b), .reject_o(rej_b),
    .run_cycles_o(cyc_b));

  core_launch_ctrl #(.ADDR_W(AW), .CNT_W(4)) u_small (
    .clk(clk), .n_reset_i(n_reset), .start_i(start), .start_pc_i(start_pc),
    .timeout_i(4'd0), .clear_i(clear), .core_state_i(core),
    .pkt_valid_o(vld_s), .pkt_ready_i(ready), .pkt_pc_o(pc_s), .busy_o(busy_s),
    .done_o(done_s), .err_o(err_s), .timeout_o(tmo_s), .reject_o(rej_s),
    .run_cycles_o(cyc_s));

  function automatic logic [AW-1:0] get_pc(input int i);
    return (i != 0) ? pc_s : pc_b;
  endfunction

  function automatic int get_cyc(input int i);
    return (i != 0) ? int'(cyc_s) : int'(cyc_b);
  endfunction

  // Outcome of a launch, in edges after the accept edge: eh is when the core
  // leaves RUN (to IDLE or ERR), T the budget, M the counter ceiling.
  // kind 0 = done, 1 = timeout, 2 = core fault.
  function automatic void predict(input int t, input int m, input int eh, input bit fin_err,
                                  output int kind, output int k, output int cnt);
    int te;
    te = (t != 0) ? t + 1 : 32'h3fff_ffff;
    if (fin_err && eh <= te) begin
      kind = 2; k = eh; cnt = (eh - 1 > m) ? m : eh - 1;
    end else if (te <= eh) begin
      kind = 1; k = te; cnt = t;
    end else begin
      kind = 0; k = eh; cnt = (eh > m) ? m : eh;
    end
  endfunction

  // One launch: bp cycles of backpressure, core RUN w cycles after accept for
  // r cycles, then IDLE (or ERR when fin_err).
  task automatic test_launch(input string nm, input logic [AW-1:0] p, input int t,
                             input int bp, input int w, input int r, input bit fin_err);
    int h, eh, last;
    int kind[2], ke[2], ce[2];
    int vn[2], pbad[2], ebad[2], dn[2], dj[2], dbusy[2], tn[2], tj[2], rn[2], eend[2], cend[2];
    h = bp + 1;
    eh = w + r;
    last = h + eh + 2;
    predict(t, 65535, eh, fin_err, kind[0], ke[0], ce[0]);
    predict(0, 15, eh, fin_err, kind[1], ke[1], ce[1]);
    for (int i = 0; i < 2; i++) begin
      vn[i] = 0; pbad[i] = 0; ebad[i] = 0; dn[i] = 0; dj[i] = -1; dbusy[i] = 0;
      tn[i] = 0; tj[i] = -1; rn[i] = 0; eend[i] = 0; cend[i] = 0;
    end
    for (int j = 0; j <= last; j++) begin
      start    = (j == 0);
      start_pc = (j == 0) ? p : AW'($urandom);
      tmo_in   = (j == 0) ? 16'(t) : 16'($urandom);
      ready    = (j >= h);
      if (j < h + w)       core = IDLE;
      else if (j < h + eh) core = RUN;
      else                 core = fin_err ? ERR : IDLE;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (vld[i]) begin
          vn[i]++;
          if (get_pc(i) !== p) pbad[i]++;
        end
        if (j < h && get_cyc(i) != 0) ebad[i]++;
        if (done[i]) begin dn[i]++; dj[i] = j - h; dbusy[i] = int'(busy[i]); end
        if (tmo[i]) begin tn[i]++; tj[i] = j - h; end
        if (rej[i]) rn[i]++;
        eend[i] = int'(err[i]);
        cend[i] = get_cyc(i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (vn[i] != h) begin n_bad++; $display("FAIL %s[%0d] valid_cycles: got %0d want %0d", nm, i, vn[i], h); end
      n_cmp++;
      if (pbad[i] != 0) begin n_bad++; $display("FAIL %s[%0d] pkt_pc: %0d cycles differ from %h", nm, i, pbad[i], p); end
      n_cmp++;
      if (ebad[i] != 0) begin n_bad++; $display("FAIL %s[%0d] count_before_accept: %0d nonzero cycles, want 0", nm, i, ebad[i]); end
      n_cmp++;
      if (dn[i] != int'(kind[i] == 0)) begin n_bad++; $display("FAIL %s[%0d] done_pulses: got %0d want %0d", nm, i, dn[i], int'(kind[i] == 0)); end
      if (kind[i] == 0) begin
        n_cmp++;
        if (dj[i] != ke[i] || dbusy[i] != 0) begin
          n_bad++; $display("FAIL %s[%0d] done_timing: got edge %0d busy %0d want edge %0d busy 0", nm, i, dj[i], dbusy[i], ke[i]);
        end
      end
      n_cmp++;
      if (tn[i] != int'(kind[i] == 1)) begin n_bad++; $display("FAIL %s[%0d] timeout_pulses: got %0d want %0d", nm, i, tn[i], int'(kind[i] == 1)); end
      if (kind[i] == 1) begin
        n_cmp++;
        if (tj[i] != ke[i]) begin n_bad++; $display("FAIL %s[%0d] timeout_edge: got %0d want %0d", nm, i, tj[i], ke[i]); end
      end
      n_cmp++;
      if (eend[i] != int'(kind[i] != 0)) begin n_bad++; $display("FAIL %s[%0d] err_level: got %0d want %0d", nm, i, eend[i], int'(kind[i] != 0)); end
      n_cmp++;
      if (cend[i] != ce[i]) begin n_bad++; $display("FAIL %s[%0d] run_cycles: got %0d want %0d", nm, i, cend[i], ce[i]); end
      n_cmp++;
      if (rn[i] != 0) begin n_bad++; $display("FAIL %s[%0d] reject_pulses: got %0d want 0", nm, i, rn[i]); end
    end
    start = 1'b0; ready = 1'b0; core = IDLE; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_cmp++;
    if (err !== 2'b00 || busy !== 2'b00) begin
      n_bad++; $display("FAIL %s after_clear: err %b busy %b want 00 00", nm, err, busy);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({vld, busy, done, err, tmo, rej} !== 12'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0", {vld, busy, done, err, tmo, rej});
    end
    n_cmp++;
    if (pc_b !== '0 || pc_s !== '0 || cyc_b !== '0 || cyc_s !== '0) begin
      n_bad++; $display("FAIL reset_data: pc %h/%h cycles %0d/%0d want 0", pc_b, pc_s, cyc_b, cyc_s);
    end
    @(negedge clk) n_reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 2'b00 || vld !== 2'b00) begin
      n_bad++; $display("FAIL reset_release: busy %b valid %b want 00 00", busy, vld);
    end
  endtask

  task automatic test_normal();       test_launch("normal", 10'h040, 0, 0, 1, 20, 1'b0); endtask
  task automatic test_backpressure(); test_launch("backpressure", 10'h2a5, 0, 5, 2, 6, 1'b0); endtask
  task automatic test_timeout();      test_launch("timeout", 10'h155, 10, 0, 1, 30, 1'b0); endtask
  task automatic test_fault();        test_launch("fault_vs_timeout", 10'h0f3, 10, 0, 1, 10, 1'b1); endtask
  task automatic test_saturation();   test_launch("saturation", 10'h3ff, 0, 1, 1, 19, 1'b0); endtask

  task automatic test_reject();
    core = RUN; start = 1'b1; start_pc = 10'h123; tmo_in = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (rej !== 2'b11 || vld !== 2'b00 || busy !== 2'b00) begin
      n_bad++; $display("FAIL reject_pulse: reject %b valid %b busy %b want 11 00 00", rej, vld, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rej !== 2'b00) begin n_bad++; $display("FAIL reject_width: reject %b want 00", rej); end
    // drive both instances into S_ERR through a core fault in S_WAIT_RUN
    core = IDLE; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    core = ERR;
    @(posedge clk); #1;
    core = IDLE; start = 1'b1; ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rej !== 2'b00 || err !== 2'b11 || vld !== 2'b00) begin
        n_bad++; $display("FAIL start_in_err: reject %b err %b valid %b want 00 11 00", rej, err, vld);
      end
    end
    start = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_cmp++;
    if (err !== 2'b00) begin n_bad++; $display("FAIL clear_err: err %b want 00", err); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      test_launch("random", AW'($urandom),
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : 0,
                  int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
                  int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async_reset();
    core = IDLE; start = 1'b1; start_pc = 10'h1c7; ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (vld !== 2'b11) begin n_bad++; $display("FAIL send_before_reset: valid %b want 11", vld); end
    #2 n_reset = 1'b0;
    #1;
    n_cmp++;
    if (vld !== 2'b00 || busy !== 2'b00) begin
      n_bad++; $display("FAIL async_reset_drop: valid %b busy %b want 00 00", vld, busy);
    end
    @(negedge clk) n_reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (vld !== 2'b00 || busy !== 2'b00 || err !== 2'b00) begin
      n_bad++; $display("FAIL after_async_reset: valid %b busy %b err %b want idle", vld, busy, err);
    end
    test_launch("post_reset", 10'h2b1, 0, 0, 1, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_fault();
    test_saturation();
    test_reject();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
